// File: rtl/add_arbiter.sv
// add_arbiter: grants one of four sources a burst on a shared 2-bit adder.
// Ports: clk, rst (async high); req[3:0], wave_a/wave_b[7:0], burst_len in;
// in1/in2 operands, gnt one-hot, busy, burst_done, sum_valid out.
// Macro ARB_FIXED_PRI_EN: fixed priority (req[0] highest) instead of round-robin.
module add_arbiter #(
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [7:0]         wave_a,
  input  logic [7:0]         wave_b,
  input  logic [BURST_W-1:0] burst_len,
  output logic [1:0]         in1,
  output logic [1:0]         in2,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               burst_done,
  output logic               sum_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           owner_q, owner_d;
  logic [3:0]           gnt_q, gnt_d;
  logic [1:0]           in1_q, in1_d;
  logic [1:0]           in2_q, in2_d;
  logic                 sv_q, sv_d;
  logic                 done;
  logic [1:0]           win;

`ifdef ARB_FIXED_PRI_EN
  // Descending scan so the lowest set index is written last.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`else
  logic [1:0] last_q, last_d;
  logic [1:0] idx;

  // Scan offsets 3..1..0 from last_q+1 so the nearest one wins.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_q + 2'(k + 1);
      if (req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 2'd3;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done    = 1'b0;
`ifndef ARB_FIXED_PRI_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (|req) begin
          state_d = XFER;
          owner_d = win;
          cnt_d   = burst_len;
          gnt_d   = 4'b0001 << win;
`ifndef ARB_FIXED_PRI_EN
          last_d  = win;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // Last beat: count exhausted or owner withdrew its request.
        if (cnt_q == '0 || !req[owner_q]) begin
          done    = 1'b1;
          state_d = (|req) ? ARB : IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Operands load on the edge entering/continuing XFER, so they are
  // non-zero exactly while the FSM sits in XFER.
  always_comb begin
    in1_d = 2'b00;
    in2_d = 2'b00;
    if (state_d == XFER) begin
      in1_d = wave_a[{owner_d, 1'b0} +: 2];
      in2_d = wave_b[{owner_d, 1'b0} +: 2];
    end
    sv_d = (state_q == XFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 2'd0;
      gnt_q   <= 4'b0000;
      in1_q   <= 2'b00;
      in2_q   <= 2'b00;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sv_q    <= sv_d;
    end
  end

  assign in1        = in1_q;
  assign in2        = in2_q;
  assign gnt        = gnt_q;
  assign busy       = (state_q == XFER);
  assign burst_done = done;
  assign sum_valid  = sv_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter.
// Covers reset, single burst, rotation, early drop, max burst, abort, idle.
module tb_add_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] wave_a = 8'h00;
  logic [7:0] wave_b = 8'h00;
  logic [3:0] burst_len = 4'd0;
  logic [1:0] in1, in2;
  logic [3:0] gnt;
  logic       busy, burst_done, sum_valid;

  int total = 0;
  int bad   = 0;

  add_arbiter #(.BURST_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wave_a     (wave_a),
    .wave_b     (wave_b),
    .burst_len  (burst_len),
    .in1        (in1),
    .in2        (in2),
    .gnt        (gnt),
    .busy       (busy),
    .burst_done (burst_done),
    .sum_valid  (sum_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Observation vector: {gnt, busy, burst_done, sum_valid, in1, in2}
  task automatic test_reset();
    logic [10:0] obs;
    do_reset();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    obs = {gnt, busy, burst_done, sum_valid, in1, in2};
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", obs, 11'd0);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [10:0] obs;
    logic [10:0] exp [6];
    exp[0] = 11'b0000_0_0_0_00_00;
    exp[1] = 11'b0001_1_0_0_01_10;
    exp[2] = 11'b0001_1_0_1_01_10;
    exp[3] = 11'b0001_1_1_1_01_10;
    exp[4] = 11'b0000_0_0_1_00_00;
    exp[5] = 11'b0000_0_0_0_00_00;
    do_reset();
    req = 4'b0001;
    burst_len = 4'd2;
    wave_a = 8'h01;
    wave_b = 8'h02;
    for (int i = 0; i < 6; i++) begin
      cyc();
      obs = {gnt, busy, burst_done, sum_valid, in1, in2};
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL basic_c%0d got=%b want=%b", i, obs, exp[i]);
      end
      if (i == 3) req = 4'b0000;
    end
  endtask

  task automatic test_rr();
    logic [3:0] eg;
    logic [1:0] ei;
    do_reset();
    req = 4'b1111;
    burst_len = 4'd0;
    wave_a = 8'hE4;
    wave_b = 8'h1B;
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || in1 !== 2'b00) begin
        bad++;
        $display("FAIL rr_arb%0d gnt=%b busy=%b in1=%b want 0", k, gnt, busy, in1);
      end
`ifdef ARB_FIXED_PRI_EN
      ei = 2'd0;
`else
      ei = 2'(k % 4);
`endif
      eg = 4'b0001 << ei;
      cyc();
      total++;
      if (gnt !== eg || in1 !== ei || in2 !== ~ei || burst_done !== 1'b1) begin
        bad++;
        $display("FAIL rr_xfer%0d gnt=%b in1=%b in2=%b done=%b want gnt=%b in1=%b in2=%b done=1",
                 k, gnt, in1, in2, burst_done, eg, ei, ~ei);
      end
    end
    req = 4'b0000;
    cyc();
    cyc();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_end gnt=%b busy=%b want 0", gnt, busy);
    end
  endtask

  task automatic test_drop();
    int svcnt;
    svcnt = 0;
    do_reset();
    req = 4'b0100;
    burst_len = 4'd15;
    wave_a = 8'h20;
    wave_b = 8'h10;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      svcnt += int'(sum_valid);
      total++;
      if (gnt !== 4'b0100 || burst_done !== 1'b0 || in1 !== 2'b10 || in2 !== 2'b01) begin
        bad++;
        $display("FAIL drop_x%0d gnt=%b done=%b in1=%b in2=%b want 0100/0/10/01",
                 i, gnt, burst_done, in1, in2);
      end
    end
    cyc();
    req = 4'b0000;
    #1;
    svcnt += int'(sum_valid);
    total++;
    if (burst_done !== 1'b1 || gnt !== 4'b0100) begin
      bad++;
      $display("FAIL drop_last done=%b gnt=%b want 1/0100", burst_done, gnt);
    end
    cyc();
    svcnt += int'(sum_valid);
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || burst_done !== 1'b0) begin
      bad++;
      $display("FAIL drop_after gnt=%b busy=%b done=%b want 0", gnt, busy, burst_done);
    end
    cyc();
    svcnt += int'(sum_valid);
    total++;
    if (svcnt !== 4) begin
      bad++;
      $display("FAIL drop_svcount got=%0d want=4", svcnt);
    end
  endtask

  task automatic test_maxburst();
    int dones;
    dones = 0;
    do_reset();
    req = 4'b0001;
    burst_len = 4'd15;
    wave_a = 8'h00;
    wave_b = 8'h00;
    cyc();
    for (int i = 0; i < 16; i++) begin
      cyc();
      dones += int'(burst_done);
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || in1 !== 2'(i % 4) ||
          burst_done !== (i == 15)) begin
        bad++;
        $display("FAIL max_x%0d gnt=%b busy=%b in1=%b done=%b want 0001/1/%0d/%0d",
                 i, gnt, busy, in1, burst_done, i % 4, i == 15);
      end
      wave_a = 8'(((i + 1) % 4));
    end
    req = 4'b0000;
    cyc();
    total++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || dones !== 1) begin
      bad++;
      $display("FAIL max_end busy=%b gnt=%b dones=%0d want 0/0000/1", busy, gnt, dones);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    do_reset();
    req = 4'b0001;
    burst_len = 4'd5;
    wave_a = 8'hFF;
    wave_b = 8'hFF;
    cyc();
    cyc();
    cyc();
    total++;
    if (busy !== 1'b1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL abort_pre busy=%b gnt=%b want 1/0001", busy, gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {gnt, busy, burst_done, sum_valid, in1, in2};
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL abort_async got=%b want=%b", obs, 11'd0);
    end
    cyc();
    obs = {gnt, busy, burst_done, sum_valid, in1, in2};
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL abort_hold got=%b want=%b", obs, 11'd0);
    end
    rst = 1'b0;
    req = 4'b1010;
    cyc();
    cyc();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL abort_regrant gnt=%b want=0010", gnt);
    end
    req = 4'b0000;
    cyc();
    cyc();
  endtask

  task automatic test_idle();
    logic [10:0] obs;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc();
      obs = {gnt, busy, burst_done, sum_valid, in1, in2};
      total++;
      if (obs !== 11'd0) begin
        bad++;
        $display("FAIL idle_c%0d got=%b want=%b", i, obs, 11'd0);
      end
    end
    req = 4'b0001;
    cyc();
    req = 4'b0000;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_arb gnt=%b busy=%b want 0", gnt, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      obs = {gnt, busy, burst_done, sum_valid, in1, in2};
      total++;
      if (obs !== 11'd0) begin
        bad++;
        $display("FAIL idle_back%0d got=%b want=%b", i, obs, 11'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_drop();
    test_maxburst();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter BURST_W, default 4, width of burst length field; max burst = 2^BURST_W cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request per source; req[i] high = source i wants the shared adder.
REQ-005 wave_a  input  8  source i first operand on bits [2i+1:2i].
REQ-006 wave_b  input  8  source i second operand on bits [2i+1:2i].
REQ-007 burst_len  input  BURST_W  burst length minus one; sampled at grant.
REQ-008 in1  output  2  operand A to shared adder, registered.
REQ-009 in2  output  2  operand B to shared adder, registered.
REQ-010 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-011 busy  output  1  high while a burst owns the adder.
REQ-012 burst_done  output  1  one-cycle pulse on last transfer cycle of a burst.
REQ-013 sum_valid  output  1  high when adder registered output holds a granted-source sum.

Function
REQ-014 FSM states: IDLE, ARB, XFER; encoding free.
REQ-015 IDLE: gnt=0, busy=0, in1=in2=2'b00; any req bit high -> ARB next cycle.
REQ-016 ARB: one cycle; select winner per REQ-020; latch burst_len into counter; set gnt one-hot; -> XFER; if req all-zero in ARB -> IDLE, gnt stays 0.
REQ-017 XFER: each cycle in1/in2 <= granted source's wave_a/wave_b slice; counter decrements; busy=1.
REQ-018 XFER end: counter==0 or req[owner] low -> burst_done pulse that cycle; next state ARB if any req high, else IDLE; gnt cleared on exit.
REQ-019 Early drop: req[owner] deasserted in XFER -> no further transfers from that source; burst_done still pulses exactly once.
REQ-020 Winner (default): round-robin; search starts at index (last_owner+1) mod 4, ascending with wrap; last_owner resets to 3 so first search starts at 0.
REQ-021 Burst length: burst_len=N gives exactly N+1 XFER cycles; N=0 gives one cycle; N=2^BURST_W-1 gives max without counter wrap.
REQ-022 Operand changes on source wave inputs during XFER are passed through cycle by cycle; no operand latching beyond the 1-cycle register.
REQ-023 sum_valid = 1-cycle delayed copy of (state==XFER), aligning with the adder's one-register latency.
REQ-024 gnt never has more than one bit set; gnt!=0 iff state==XFER.
REQ-025 Back-to-back bursts separated by exactly one ARB cycle (in1/in2 hold 2'b00 during ARB).

Reset
REQ-026 rst high: state=IDLE, in1=in2=2'b00, gnt=4'b0000, busy=0, burst_done=0, sum_valid=0, counter=0, last_owner=3, immediately, independent of clk.
REQ-027 rst asserted mid-burst aborts it with no burst_done pulse; first ARB after release starts search at index 0.

Configuration
REQ-028 Macro ARB_FIXED_PRI_EN: defined -> winner is lowest-index high req (req[0] highest), last_owner unused; undefined -> round-robin per REQ-020.
REQ-029 All other behaviour identical with or without ARB_FIXED_PRI_EN.

Verification
REQ-030 req=4'b0001, burst_len=2, wave_a[1:0]=2'b01, wave_b[1:0]=2'b10 -> ARB 1 cycle, gnt=0001 for 3 cycles, in1=01/in2=10, burst_done on 3rd, sum_valid 3 cycles lagging 1, then IDLE.
REQ-031 req=4'b1111 held, burst_len=0 -> grant order 0001,0010,0100,1000,0001 with one ARB cycle between each; with ARB_FIXED_PRI_EN, gnt=0001 every burst.
REQ-032 req=4'b0100, burst_len=15, drop req[2] after 4 XFER cycles -> burst_done on 4th cycle, gnt=0 next, 4 sum_valid cycles total.
REQ-033 rst pulsed during XFER of burst_len=5 -> all outputs zero within the same cycle, no burst_done; after release, req=4'b1010 -> gnt=0010 first.
REQ-034 req=0 throughout -> FSM stays IDLE, all outputs zero for 20 cycles; req pulse high in IDLE then low in ARB -> return to IDLE, gnt never set.
